// File: rtl/gcm_arb_pkg.sv
// Shared types for the two-requester GCM engine stream arbiter:
// FSM state encoding, requester index type and the default stream width.
package gcm_arb_pkg;

  localparam int unsigned GCM_ARB_DATA_WIDTH = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RSP   = 2'd2,
    FLUSH = 2'd3
  } arb_state_e;

  typedef logic req_idx_t;

  function automatic logic [1:0] idx_to_onehot(input req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/gcm_arb_watchdog.sv
// Response-stall watchdog for gcm_stream_arbiter: counts stalled response cycles
// and times the engine reset pulse used to recover a hung engine.
module gcm_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned RST_CYCLES     = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rsp_active_i,
  input  logic rsp_stall_i,
  input  logic rsp_hs_i,
  input  logic flush_active_i,
  output logic timeout_o,
  output logic flush_first_o,
  output logic flush_done_o
);

  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FLUSH_W = $clog2(RST_CYCLES + 1);

  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;

  // Downstream hold-off (engine valid, requester not ready) is not a stall: the count holds.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!rsp_active_i || rsp_hs_i) begin
      stall_cnt_d = '0;
    end else if (rsp_stall_i) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    flush_cnt_d = '0;
    if (flush_active_i) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign timeout_o     = rsp_active_i && rsp_stall_i &&
                         (stall_cnt_q == STALL_W'(TIMEOUT_CYCLES - 1));
  assign flush_first_o = flush_active_i && (flush_cnt_q == '0);
  assign flush_done_o  = flush_active_i && (flush_cnt_q == FLUSH_W'(RST_CYCLES - 1));

endmodule

// File: rtl/gcm_stream_arbiter.sv
// Round-robin packet arbiter sharing one GCM engine between two AXI-Stream requesters.
// Optional response-stall recovery is built when GCM_ARB_WATCHDOG_EN is defined.
module gcm_stream_arbiter
  import gcm_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = GCM_ARB_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned RST_CYCLES     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  input  logic                  s0_tvalid,
  input  logic                  s0_tlast,
  output logic                  s0_tready,
  input  logic [DATA_WIDTH-1:0] s1_tdata,
  input  logic                  s1_tvalid,
  input  logic                  s1_tlast,
  output logic                  s1_tready,
  output logic [DATA_WIDTH-1:0] m0_tdata,
  output logic                  m0_tvalid,
  output logic                  m0_tlast,
  input  logic                  m0_tready,
  output logic [DATA_WIDTH-1:0] m1_tdata,
  output logic                  m1_tvalid,
  output logic                  m1_tlast,
  input  logic                  m1_tready,
  output logic [DATA_WIDTH-1:0] eng_s_tdata,
  output logic                  eng_s_tvalid,
  output logic                  eng_s_tlast,
  input  logic                  eng_s_tready,
  input  logic [DATA_WIDTH-1:0] eng_m_tdata,
  input  logic                  eng_m_tvalid,
  input  logic                  eng_m_tlast,
  output logic                  eng_m_tready,
  output logic                  eng_rst_n,
  output logic [1:0]            grant,
  output logic                  err_timeout
);

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  req_idx_t   last_grant_q, last_grant_d;
  logic       eng_rst_n_q, eng_rst_n_d;
  req_idx_t   owner;
  logic       req_hs, rsp_hs;
  logic       wd_timeout, wd_flush_done;

  assign owner = grant_q[1];

  // A beat transfers on a cycle where valid and ready are both high; valid never waits on ready.
  // Data is a zero-latency mux; only valid/last/ready are gated by the phase.
  always_comb begin
    eng_s_tdata  = owner ? s1_tdata : s0_tdata;
    eng_s_tvalid = 1'b0;
    eng_s_tlast  = 1'b0;
    s0_tready    = 1'b0;
    s1_tready    = 1'b0;
    m0_tdata     = eng_m_tdata;
    m1_tdata     = eng_m_tdata;
    m0_tvalid    = 1'b0;
    m0_tlast     = 1'b0;
    m1_tvalid    = 1'b0;
    m1_tlast     = 1'b0;
    eng_m_tready = 1'b0;
    if (state_q == REQ) begin
      eng_s_tvalid = owner ? s1_tvalid : s0_tvalid;
      eng_s_tlast  = owner ? s1_tlast : s0_tlast;
      s0_tready    = grant_q[0] & eng_s_tready;
      s1_tready    = grant_q[1] & eng_s_tready;
    end
    if (state_q == RSP) begin
      m0_tvalid    = grant_q[0] & eng_m_tvalid;
      m0_tlast     = grant_q[0] & eng_m_tlast;
      m1_tvalid    = grant_q[1] & eng_m_tvalid;
      m1_tlast     = grant_q[1] & eng_m_tlast;
      eng_m_tready = owner ? m1_tready : m0_tready;
    end
  end

  assign req_hs = eng_s_tvalid & eng_s_tready;
  assign rsp_hs = eng_m_tvalid & eng_m_tready;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (s0_tvalid || s1_tvalid) begin
          if (s0_tvalid && s1_tvalid) begin
            grant_d = idx_to_onehot(~last_grant_q);
          end else begin
            grant_d = s1_tvalid ? 2'b10 : 2'b01;
          end
          state_d = REQ;
        end
      end
      REQ: begin
        if (req_hs && eng_s_tlast) begin
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_hs && eng_m_tlast) begin
          last_grant_d = owner;
          grant_d      = 2'b00;
          state_d      = IDLE;
        end else if (wd_timeout) begin
          // The stalled owner counts as served so the other requester goes next.
          last_grant_d = owner;
          grant_d      = 2'b00;
          state_d      = FLUSH;
        end
      end
      FLUSH: begin
        if (wd_flush_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    eng_rst_n_d = (state_d != FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      eng_rst_n_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      eng_rst_n_q  <= eng_rst_n_d;
    end
  end

  assign grant     = grant_q;
  assign eng_rst_n = eng_rst_n_q;

`ifdef GCM_ARB_WATCHDOG_EN
  logic wd_flush_first;

  gcm_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .RST_CYCLES    (RST_CYCLES)
  ) u_watchdog (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .rsp_active_i  (state_q == RSP),
    .rsp_stall_i   (~eng_m_tvalid),
    .rsp_hs_i      (rsp_hs),
    .flush_active_i(state_q == FLUSH),
    .timeout_o     (wd_timeout),
    .flush_first_o (wd_flush_first),
    .flush_done_o  (wd_flush_done)
  );

  assign err_timeout = wd_flush_first;
`else
  // FLUSH is unreachable without the watchdog; should it ever be entered, leave at once.
  assign wd_timeout    = 1'b0;
  assign wd_flush_done = (TIMEOUT_CYCLES > 0) && (RST_CYCLES > 0);
  assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_gcm_stream_arbiter.sv
// Directed bench for gcm_stream_arbiter: arbitration order, packet pass-through,
// backpressure, late contender, stall handling (watchdog if GCM_ARB_WATCHDOG_EN) and reset.
module tb_gcm_stream_arbiter;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s0_tdata, s1_tdata, m0_tdata, m1_tdata, eng_s_tdata, eng_m_tdata;
  logic          s0_tvalid, s0_tlast, s0_tready, s1_tvalid, s1_tlast, s1_tready;
  logic          m0_tvalid, m0_tlast, m0_tready, m1_tvalid, m1_tlast, m1_tready;
  logic          eng_s_tvalid, eng_s_tlast, eng_s_tready;
  logic          eng_m_tvalid, eng_m_tlast, eng_m_tready;
  logic          eng_rst_n, err_timeout;
  logic [1:0]    grant;

  int n_tests = 0;
  int n_fail  = 0;

  gcm_stream_arbiter #(
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(16),
    .RST_CYCLES    (4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .m0_tdata(m0_tdata), .m0_tvalid(m0_tvalid), .m0_tlast(m0_tlast), .m0_tready(m0_tready),
    .m1_tdata(m1_tdata), .m1_tvalid(m1_tvalid), .m1_tlast(m1_tlast), .m1_tready(m1_tready),
    .eng_s_tdata(eng_s_tdata), .eng_s_tvalid(eng_s_tvalid), .eng_s_tlast(eng_s_tlast),
    .eng_s_tready(eng_s_tready),
    .eng_m_tdata(eng_m_tdata), .eng_m_tvalid(eng_m_tvalid), .eng_m_tlast(eng_m_tlast),
    .eng_m_tready(eng_m_tready),
    .eng_rst_n(eng_rst_n), .grant(grant), .err_timeout(err_timeout)
  );

  // Clock / global time limit
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives n request beats from requester idx; entered in REQ, leaves in RSP.
  task automatic do_req(input int idx, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      if (idx == 0) begin
        s0_tvalid = 1'b1; s0_tdata = base + i; s0_tlast = (i == n - 1);
      end else begin
        s1_tvalid = 1'b1; s1_tdata = base + i; s1_tlast = (i == n - 1);
      end
      eng_s_tready = 1'b1;
      #1;
      chk("req_grant", grant, (idx == 0) ? 2'b01 : 2'b10);
      chk("req_eng_s_tvalid", eng_s_tvalid, 1);
      chk("req_eng_s_tdata", eng_s_tdata, base + i);
      chk("req_eng_s_tlast", eng_s_tlast, (i == n - 1));
      chk("req_own_tready", (idx == 0) ? s0_tready : s1_tready, 1);
      chk("req_other_tready", (idx == 0) ? s1_tready : s0_tready, 0);
      chk("req_eng_m_tready", eng_m_tready, 0);
      chk("req_m_tvalid", m0_tvalid | m1_tvalid, 0);
      tick();
    end
  endtask

  // Engine model returns n beats base, base+1, ...; advances only on a handshake.
  task automatic do_rsp(input int idx, input int n, input logic [31:0] base, input logic [3:0] pat);
    int k;
    int c;
    k = 0;
    c = 0;
    while (k < n && c < 32) begin
      logic rdy;
      rdy          = pat[3 - (c % 4)];
      eng_m_tvalid = 1'b1;
      eng_m_tdata  = base + k;
      eng_m_tlast  = (k == n - 1);
      if (idx == 0) begin m0_tready = rdy; m1_tready = 1'b1; end
      else begin m1_tready = rdy; m0_tready = 1'b1; end
      #1;
      chk("rsp_grant", grant, (idx == 0) ? 2'b01 : 2'b10);
      chk("rsp_eng_m_tready", eng_m_tready, rdy);
      chk("rsp_own_tvalid", (idx == 0) ? m0_tvalid : m1_tvalid, 1);
      chk("rsp_own_tdata", (idx == 0) ? m0_tdata : m1_tdata, base + k);
      chk("rsp_own_tlast", (idx == 0) ? m0_tlast : m1_tlast, (k == n - 1));
      chk("rsp_other_tvalid", (idx == 0) ? m1_tvalid : m0_tvalid, 0);
      chk("rsp_eng_s_tvalid", eng_s_tvalid, 0);
      chk("rsp_s_tready", s0_tready | s1_tready, 0);
      tick();
      if (rdy) k++;
      c++;
    end
    eng_m_tvalid = 1'b0;
    eng_m_tlast  = 1'b0;
    m0_tready    = 1'b0;
    m1_tready    = 1'b0;
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_eng_rst_n"}, eng_rst_n, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
    chk({tag, "_s_tready"}, {s0_tready, s1_tready}, 0);
    chk({tag, "_eng_s"}, {eng_s_tvalid, eng_s_tlast}, 0);
    chk({tag, "_eng_m_tready"}, eng_m_tready, 0);
    chk({tag, "_m_valid_last"}, {m0_tvalid, m0_tlast, m1_tvalid, m1_tlast}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    s0_tdata = '0; s0_tvalid = 1'b0; s0_tlast = 1'b0;
    s1_tdata = '0; s1_tvalid = 1'b0; s1_tlast = 1'b0;
    m0_tready = 1'b0; m1_tready = 1'b0; eng_s_tready = 1'b0;
    eng_m_tdata = '0; eng_m_tvalid = 1'b0; eng_m_tlast = 1'b0;
    tick();
    tick();
    chk_reset_outputs("reset");

    // Tie on the cycle after reset: 4 transactions alternate 0,1,0,1
    rst_n = 1'b1;
    s0_tvalid = 1'b1; s1_tvalid = 1'b1; s0_tlast = 1'b1; s1_tlast = 1'b1;
    eng_s_tready = 1'b1;
    #1;
    chk("tie_idle_grant", grant, 0);
    chk("tie_idle_s0_tready", s0_tready, 0);
    tick();
    chk("eng_rst_rise", eng_rst_n, 1);
    for (int t = 0; t < 4; t++) begin
      chk("tie_order", grant, (t % 2 == 0) ? 2'b01 : 2'b10);
      do_req(t % 2, 1, 32'h100 + t * 16);
      do_rsp(t % 2, 1, 32'h200 + t * 16, 4'b1111);
      chk("tie_gap_grant", grant, 0);
      if (t == 3) begin s0_tvalid = 1'b0; s1_tvalid = 1'b0; end
      tick();
    end
    chk("tie_end_grant", grant, 0);

    // Single requester, 4-beat request, 3-beat response; engine beat offered early is held
    s0_tvalid = 1'b1; s0_tdata = 32'hA0; s0_tlast = 1'b0;
    eng_m_tvalid = 1'b1; eng_m_tdata = 32'hC0;
    #1;
    chk("single_idle_eng_m_tready", eng_m_tready, 0);
    tick();
    do_req(0, 4, 32'hA0);
    s0_tvalid = 1'b0; s0_tlast = 1'b0;
    do_rsp(0, 3, 32'hC0, 4'b1111);
    chk("single_grant_after", grant, 0);

    // Backpressure 1010 on m1 during a 4-beat response
    s1_tvalid = 1'b1;
    tick();
    do_req(1, 2, 32'hB0);
    s1_tvalid = 1'b0; s1_tlast = 1'b0;
    do_rsp(1, 4, 32'hD0, 4'b1010);
    chk("bp_grant_after", grant, 0);

    // Late contender: s1 rises while s0 is in RSP
    s0_tvalid = 1'b1;
    tick();
    do_req(0, 1, 32'hE0);
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b1; s1_tdata = 32'hF0; s1_tlast = 1'b1;
    do_rsp(0, 2, 32'hE8, 4'b1111);
    chk("late_idle_s1_tready", s1_tready, 0);
    chk("late_idle_grant", grant, 0);
    tick();
    chk("late_grant", grant, 2'b10);
    chk("late_s1_tready", s1_tready, 1);
    do_req(1, 1, 32'hF0);
    s1_tvalid = 1'b0;
    do_rsp(1, 1, 32'hF8, 4'b1111);
    chk("late_grant_after", grant, 0);

    // Engine never responds; s1 pending
    s0_tvalid = 1'b1;
    tick();
    do_req(0, 1, 32'h300);
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b1; s1_tlast = 1'b1;
    m0_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("stall_err_low", err_timeout, 0);
      chk("stall_eng_rst_n", eng_rst_n, 1);
      chk("stall_grant", grant, 2'b01);
      tick();
    end
`ifdef GCM_ARB_WATCHDOG_EN
    chk("wd_err_pulse", err_timeout, 1);
    chk("wd_eng_rst_low0", eng_rst_n, 0);
    chk("wd_grant_flush", grant, 0);
    tick();
    for (int i = 1; i < 4; i++) begin
      chk("wd_err_single", err_timeout, 0);
      chk("wd_eng_rst_low", eng_rst_n, 0);
      tick();
    end
    chk("wd_eng_rst_high", eng_rst_n, 1);
    chk("wd_idle_grant", grant, 0);
    chk("wd_idle_err", err_timeout, 0);
    m0_tready = 1'b0;
`else
    for (int i = 0; i < 8; i++) begin
      chk("nowd_err", err_timeout, 0);
      chk("nowd_eng_rst_n", eng_rst_n, 1);
      chk("nowd_grant", grant, 2'b01);
      tick();
    end
    do_rsp(0, 1, 32'h380, 4'b1111);
    chk("nowd_idle_grant", grant, 0);
`endif
    tick();
    chk("stall_next_grant", grant, 2'b10);
    do_req(1, 1, 32'h390);
    s1_tvalid = 1'b0;
    do_rsp(1, 1, 32'h398, 4'b1111);
    chk("stall_s1_done", grant, 0);

    // Leave last_grant on requester 0 so the post-reset tie shows it was reset
    s0_tvalid = 1'b1;
    tick();
    do_req(0, 1, 32'h3A0);
    s0_tvalid = 1'b0;
    do_rsp(0, 1, 32'h3A8, 4'b1111);

    // Reset asserted during the 2nd request beat
    s0_tvalid = 1'b1; s0_tlast = 1'b0; s0_tdata = 32'h400;
    tick();
    #1;
    chk("rst_mid_beat1", eng_s_tdata, 32'h400);
    tick();
    s0_tdata = 32'h401; rst_n = 1'b0;
    #1;
    chk("rst_mid_beat2", eng_s_tvalid, 1);
    tick();
    chk_reset_outputs("rst_mid");
    rst_n = 1'b1; s1_tvalid = 1'b1; s0_tlast = 1'b1; s1_tlast = 1'b1;
    tick();
    chk("rst_eng_rst_rise", eng_rst_n, 1);
    chk("rst_tie_grant", grant, 2'b01);
    do_req(0, 1, 32'h410);
    s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    do_rsp(0, 1, 32'h418, 4'b1111);
    chk("rst_final_grant", grant, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
